// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch stage: data-path width, the
// bubble encoding, the fetch FSM state type and the fetch/decode register
// payload.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- architectural no-op used to fill decode on a flush.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  // Contents of the fetch/decode pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// data_fetch_io
// Fetch-to-decode bundle. The fetch stage drives it through modport 'in';
// the decode stage consumes it through modport 'out'.
//   instr    : instruction word in decode
//   pc       : byte address of that instruction
//   pc_plus4 : pc + 4, used for link addresses
// -----------------------------------------------------------------------------
interface data_fetch_io;
  import instr_fetch_pkg::*;

  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  modport in  (output instr, output pc, output pc_plus4);
  modport out (input  instr, input  pc, input  pc_plus4);

endinterface : data_fetch_io

// File: rtl/instr_fetch_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// Fetch/decode pipeline register with synchronous clear and load enable.
//   clk : clock, rising edge
//   rst : synchronous active-low reset, loads the bubble
//   en  : load d when high (driven by ~stall_d)
//   clr : load the bubble (driven by flush_d); has priority over en
//   d   : next contents from fetch
//   q   : current contents seen by decode
// -----------------------------------------------------------------------------
module if_id_reg #(
  parameter logic [instr_fetch_pkg::XLEN-1:0] NOP_INSTR = instr_fetch_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  instr_fetch_pkg::if_id_t d,
  output instr_fetch_pkg::if_id_t q
);
  import instr_fetch_pkg::*;

  if_id_t bubble;
  if_id_t q_q;
  if_id_t q_d;

  assign bubble = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = bubble;
    end else if (en) begin
      q_d = d;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= bubble;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : if_id_reg

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: PC register, boot/run/stall FSM, instruction BRAM
// request and the fetch/decode pipeline register.
//   clk, rst        : clock; synchronous active-low reset
//   stall_f         : hold the fetch PC (hazard unit)
//   stall_d         : hold the fetch/decode register (hazard unit)
//   flush_d         : turn the fetch/decode register into a bubble
//   pc_src_e        : taken branch/jump from execute, overrides stall_f
//   pc_target_e     : redirect target
//   imem_addr/en    : BRAM request; address is the next PC (combinational)
//   imem_rdata      : BRAM data, one cycle after the request, held while !en
//   data_fetch_if   : instr / pc / pc_plus4 towards decode
//   valid_d         : decode holds a real instruction
//   fetch_cnt       : valid instructions accepted into decode (wraps)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [instr_fetch_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [instr_fetch_pkg::XLEN-1:0] NOP_INSTR = instr_fetch_pkg::NOP_INSTR
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall_f,
  input  logic                              stall_d,
  input  logic                              flush_d,
  input  logic                              pc_src_e,
  input  logic [instr_fetch_pkg::XLEN-1:0]  pc_target_e,
  output logic [instr_fetch_pkg::XLEN-1:0]  imem_addr,
  output logic                              imem_en,
  input  logic [instr_fetch_pkg::XLEN-1:0]  imem_rdata,
  data_fetch_io.in                          data_fetch_if,
  output logic                              valid_d,
  output logic [instr_fetch_pkg::XLEN-1:0]  fetch_cnt
);
  import instr_fetch_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            valid_f;
  logic            hold_f;
  logic            if_id_load;
  if_id_t          if_id_in;
  if_id_t          if_id_out;

  // A redirect always proceeds, so the PC only truly holds when stalled
  // without one.
  assign hold_f = stall_f & ~pc_src_e;

  // ---------------------------------------------------------------------------
  // Fetch FSM and next-PC selection
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    valid_f = 1'b1;

    if (pc_src_e) begin
      pc_f_d = pc_target_e;
    end else if (stall_f) begin
      pc_f_d = pc_f_q;
    end else begin
      pc_f_d = pc_f_q + 32'd4;  // wraps naturally at 32 bits
    end

    unique case (state_q)
      BOOT: begin
        // The BRAM has nothing valid yet: re-issue RESET_PC and mark the
        // first slot as a bubble.
        state_d = RUN;
        pc_f_d  = RESET_PC;
        valid_f = 1'b0;
      end
      RUN: begin
        if (hold_f) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (!hold_f) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        pc_f_d  = RESET_PC;
        valid_f = 1'b0;
      end
    endcase
  end

  // BRAM request: keeping en low while held freezes imem_rdata on the word
  // for pc_f, so decode can pick it up after the stall.
  assign imem_addr = pc_f_d;
  assign imem_en   = rst & ~hold_f;

  // ---------------------------------------------------------------------------
  // Accepted-instruction counter
  // ---------------------------------------------------------------------------
  assign if_id_load = ~flush_d & ~stall_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (if_id_load && valid_f) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= BOOT;
      pc_f_q      <= RESET_PC;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch/decode register
  // ---------------------------------------------------------------------------
  assign if_id_in = '{
    instr:    imem_rdata,
    pc:       pc_f_q,
    pc_plus4: pc_f_q + 32'd4,
    valid:    valid_f
  };

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk (clk),
    .rst (rst),
    .en  (~stall_d),
    .clr (flush_d),
    .d   (if_id_in),
    .q   (if_id_out)
  );

  assign data_fetch_if.instr    = if_id_out.instr;
  assign data_fetch_if.pc       = if_id_out.pc;
  assign data_fetch_if.pc_plus4 = if_id_out.pc_plus4;
  assign valid_d                = if_id_out.valid;
  assign fetch_cnt              = fetch_cnt_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Inputs change on the falling edge; outputs
// are compared 1 ns later, well away from the rising edge. The instruction
// memory is a one-cycle-latency BRAM model whose contents are a fixed
// function of the address.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        valid_d;
  logic [31:0] fetch_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_fetch_io dfi ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .pc_src_e      (pc_src_e),
    .pc_target_e   (pc_target_e),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .imem_rdata    (imem_rdata),
    .data_fetch_if (dfi),
    .valid_d       (valid_d),
    .fetch_cnt     (fetch_cnt)
  );

  // Memory contents: distinct per word, never equal to the bubble encoding.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fl,
                       input logic ps, input logic [31:0] tgt);
    stall_f     = sf;
    stall_d     = sd;
    flush_d     = fl;
    pc_src_e    = ps;
    pc_target_e = tgt;
  endtask

  // Decode holds the real instruction at address pc.
  task automatic check_dec(input string tag, input logic [31:0] pc);
    check({tag, ".valid"},    {31'b0, valid_d},  32'd1);
    check({tag, ".pc"},       dfi.pc,            pc);
    check({tag, ".instr"},    dfi.instr,         mem_word(pc));
    check({tag, ".pc_plus4"}, dfi.pc_plus4,      pc + 32'd4);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"},    {31'b0, valid_d}, 32'd0);
    check({tag, ".instr"},    dfi.instr,        32'h0000_0013);
    check({tag, ".pc"},       dfi.pc,           32'd0);
    check({tag, ".pc_plus4"}, dfi.pc_plus4,     32'd0);
  endtask

  // Entered at a falling edge with rst low and at least one reset edge seen.
  // Releases reset and checks the boot sequence up to the third valid slot.
  task automatic boot_seq(input string tag);
    settle;
    check_bubble({tag, ".rst"});
    check({tag, ".rst.cnt"}, fetch_cnt, 32'd0);
    check({tag, ".rst.en"},  {31'b0, imem_en}, 32'd0);

    tick; rst = 1'b1; settle;                       // BOOT cycle
    check({tag, ".c0.valid"}, {31'b0, valid_d}, 32'd0);
    check({tag, ".c0.addr"},  imem_addr, 32'h0);
    check({tag, ".c0.en"},    {31'b0, imem_en}, 32'd1);

    tick; settle;
    check({tag, ".c1.valid"}, {31'b0, valid_d}, 32'd0);
    check({tag, ".c1.addr"},  imem_addr, 32'h4);

    tick; settle;
    check_dec({tag, ".c2"}, 32'h0);
    check({tag, ".c2.cnt"}, fetch_cnt, 32'd1);

    tick; settle;
    check_dec({tag, ".c3"}, 32'h4);

    tick; settle;
    check_dec({tag, ".c4"}, 32'h8);
    check({tag, ".c4.cnt"}, fetch_cnt, 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick; tick;

    // Reset then free-run.
    boot_seq("boot");

    // Stall with pc_f = 0x10, decode holding 0x0C.
    tick; drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); settle;
    check("stall.en",   {31'b0, imem_en}, 32'd0);
    check("stall.addr", imem_addr, 32'h10);
    check_dec("stall.c5", 32'hC);
    check("stall.cnt",  fetch_cnt, 32'd4);
    for (int i = 0; i < 2; i++) begin
      tick; settle;
      check("stall.hold.en", {31'b0, imem_en}, 32'd0);
      check_dec("stall.hold", 32'hC);
      check("stall.hold.cnt", fetch_cnt, 32'd4);
    end
    tick; drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); settle;
    check("release.en",   {31'b0, imem_en}, 32'd1);
    check("release.addr", imem_addr, 32'h14);
    check_dec("release.c8", 32'hC);
    tick; settle;
    check_dec("release.c9", 32'h10);

    // Redirect to 0x200 with flush.
    tick; drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h200); settle;
    check_dec("redir.c10", 32'h14);
    check("redir.addr", imem_addr, 32'h200);
    check("redir.en",   {31'b0, imem_en}, 32'd1);
    check("redir.cnt",  fetch_cnt, 32'd6);
    tick; drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); settle;
    check_bubble("redir.c11");
    check("redir.c11.addr", imem_addr, 32'h204);
    check("redir.c11.cnt",  fetch_cnt, 32'd6);
    tick; settle;
    check_dec("redir.c12", 32'h200);
    check("redir.c12.cnt", fetch_cnt, 32'd7);

    // Redirect during stall; flush beats stall_d.
    tick; drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h300); settle;
    check_dec("redst.c13", 32'h204);
    check("redst.en",   {31'b0, imem_en}, 32'd1);
    check("redst.addr", imem_addr, 32'h300);
    tick; drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); settle;
    check_bubble("redst.c14");
    check("redst.c14.addr", imem_addr, 32'h304);
    tick; settle;
    check_dec("redst.c15", 32'h300);

    // PC wrap-around from 0xFFFF_FFFC.
    tick; drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC); settle;
    check("wrap.c16.addr", imem_addr, 32'hFFFF_FFFC);
    tick; drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); settle;
    check("wrap.c17.addr", imem_addr, 32'h0);
    check("wrap.c17.no_x", {31'b0, $isunknown(imem_addr)}, 32'd0);
    check("wrap.c17.valid", {31'b0, valid_d}, 32'd0);
    tick; settle;
    check_dec("wrap.c18", 32'hFFFF_FFFC);
    tick; drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); settle;
    check_dec("wrap.c19", 32'h0);
    check("wrap.c19.en", {31'b0, imem_en}, 32'd0);

    // Reset in the middle of a stall, with a redirect and flush also pending.
    tick; settle;
    check_dec("rstst.c20", 32'h0);
    tick; rst = 1'b0; drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h400); settle;
    check("rstst.en", {31'b0, imem_en}, 32'd0);
    tick; drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    boot_seq("reboot");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded at reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble encoding (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port stall_f  input  1  hold the fetch PC, from the hazard unit.
REQ-006 SHALL have port stall_d  input  1  hold the fetch/decode register, from the hazard unit.
REQ-007 SHALL have port flush_d  input  1  replace the fetch/decode register contents with a bubble.
REQ-008 SHALL have port pc_src_e  input  1  taken branch or jump redirect, from execute.
REQ-009 SHALL have port pc_target_e  input  32  redirect target address.
REQ-010 SHALL have port imem_addr  output  32  instruction BRAM byte address.
REQ-011 SHALL have port imem_en  output  1  instruction BRAM read enable.
REQ-012 SHALL have port imem_rdata  input  32  BRAM read data, one-cycle latency; output is held while imem_en is low.
REQ-013 SHALL have port data_fetch_if  modport data_fetch_io.in  -  drives instr[31:0], pc[31:0] and pc_plus4[31:0] to decode.
REQ-014 SHALL have port valid_d  output  1  the decode-stage instruction is real and not a bubble.
REQ-015 SHALL have port fetch_cnt  output  32  count of valid instructions accepted into decode.

Function
REQ-016 FSM states: BOOT, RUN, STALL.
REQ-017 BOOT lasts exactly one cycle after reset release and then goes to RUN unconditionally.
REQ-018 In BOOT, pc_next SHALL be RESET_PC and valid_f SHALL be 0.
REQ-019 RUN goes to STALL when stall_f=1 and pc_src_e=0.
REQ-020 STALL goes to RUN when stall_f=0 or pc_src_e=1.
REQ-021 Outside BOOT, pc_next SHALL be chosen in priority order:
- pc_src_e=1: pc_target_e;
- stall_f=1: pc_f;
- otherwise: pc_f+4, with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
REQ-022 pc_src_e SHALL override stall_f.
REQ-023 imem_addr SHALL equal pc_next, combinationally.
REQ-024 imem_en SHALL be 0 when rst=0 or (stall_f=1 and pc_src_e=0), and 1 otherwise.
REQ-025 The pc_f register SHALL load pc_next every cycle, so imem_rdata always corresponds to pc_f.
REQ-026 valid_f SHALL be 1 in RUN and STALL, and 0 in BOOT.
REQ-027 The fetch/decode register (instr, pc, pc_plus4, valid_d) SHALL update by this priority:
- flush_d=1: instr=NOP_INSTR, pc=0, pc_plus4=0, valid_d=0;
- else stall_d=1: hold all fields;
- else: load imem_rdata, pc_f, pc_f+4 and valid_f.
REQ-028 flush_d SHALL win over stall_d when both are asserted.
REQ-029 fetch_cnt SHALL increment by 1 on each edge where the fetch/decode register loads with valid_f=1 (no flush, no stall).
REQ-030 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 Latency: an instruction whose address is issued in cycle N SHALL appear on data_fetch_if in cycle N+2 when no stall occurs.
REQ-032 A redirect in cycle N SHALL fetch pc_target_e at the edge ending N, with the target instruction in decode at N+2.
- The hazard unit asserts flush_d in cycle N to squash the wrong-path instruction.
REQ-033 No combinational path SHALL exist from imem_rdata to any output other than through the fetch/decode register.

Reset
REQ-034 When rst=0 at a rising edge, the block SHALL set:
- pc_f=RESET_PC and state=BOOT;
- instr=NOP_INSTR, pc=0, pc_plus4=0;
- valid_d=0 and fetch_cnt=0.
REQ-035 Reset SHALL override stall, flush and redirect inputs.
REQ-036 Reset asserted mid-stall or mid-redirect SHALL discard that operation.
REQ-037 After release, the first valid_d=1 SHALL occur in the third cycle, with pc=RESET_PC.

Structure
REQ-038 The shared package SHALL hold:
- the fetch FSM state enum;
- the NOP_INSTR constant;
- the XLEN=32 constant.
REQ-039 The fetch/decode register SHALL be one sub-module, if_id_reg, with enable (~stall_d) and synchronous clear (flush_d).
REQ-040 The PC, the FSM and fetch_cnt SHALL reside in instr_fetch.

Verification
REQ-041 Reset then free-run: the bench SHALL check:
- valid_d=0 for two cycles;
- then pc=0, 4, 8 on consecutive cycles, with instr=mem[pc] and pc_plus4=pc+4;
- fetch_cnt=3 after three valid cycles.
REQ-042 stall_f=stall_d=1 for 3 cycles at pc_f=0x10: the bench SHALL check:
- imem_en=0 and the decode outputs are held;
- after release, pc 0x0C then 0x10 resume with no duplicate or skipped address.
REQ-043 pc_src_e=1, pc_target_e=0x200 and flush_d=1 in one cycle: the bench SHALL check:
- next cycle valid_d=0 and instr=0x00000013;
- the cycle after, pc=0x200 with valid_d=1.
REQ-044 pc_src_e=1 while stall_f=1 and stall_d=1 with flush_d=1: the bench SHALL check that the redirect is taken and the flush beats the stall.
REQ-045 pc_f=0xFFFF_FFFC running freely: the bench SHALL check that the next address is 0x0000_0000, with no X values.
REQ-046 rst=0 asserted during a stall, then released: the bench SHALL check that all outputs equal their REQ-034 reset values and the REQ-037 sequence repeats.
